// File: rtl/asm_trace_streamer.sv
// asm_trace_streamer
// Captures the CPU's right-justified ASCII disassembly string on each retire
// strobe and streams it out byte by byte over valid/ready. Leading NUL bytes
// are skipped and a terminator is appended. Strobes that arrive while a line
// is in flight are dropped and counted in a saturating counter.
//
// Optional feature: define ASM_TRACE_CR_EN to emit 8'h0D before EOL_CHAR.
module asm_trace_streamer #(
  parameter int         NBYTES   = 32,
  parameter logic [7:0] EOL_CHAR = 8'h0A,
  parameter int         DROP_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*NBYTES-1:0] asm,
  input  logic                asm_valid,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int CNT_W = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKIP,
    S_SEND,
`ifdef ASM_TRACE_CR_EN
    S_CR,
`endif
    S_EOL
  } state_t;

  state_t               state_q, state_d;
  logic [8*NBYTES-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DROP_W-1:0]    drop_cnt_q;
  logic [7:0]           top_byte;

  // The character currently at the head of the captured string.
  assign top_byte = sr_q[8*NBYTES-1 -: 8];

  // State, shift register and byte counter; reset aborts any line in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update: capture, skip leading NULs, shift on accept.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (asm_valid) begin
          sr_d    = asm;
          cnt_d   = CNT_W'(NBYTES);
          state_d = S_SKIP;
        end
      end
      S_SKIP: begin
        if (top_byte != 8'h00) begin
          // First real character found; it is sent without shifting.
          state_d = S_SEND;
        end else if (cnt_q == CNT_W'(1)) begin
          // Whole string was NUL: nothing to emit.
          state_d = S_IDLE;
        end else begin
          sr_d  = {sr_q[8*NBYTES-9:0], 8'h00};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SEND: begin
        if (out_ready) begin
          sr_d  = {sr_q[8*NBYTES-9:0], 8'h00};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef ASM_TRACE_CR_EN
            state_d = S_CR;
`else
            state_d = S_EOL;
`endif
          end
        end
      end
`ifdef ASM_TRACE_CR_EN
      S_CR: begin
        if (out_ready) state_d = S_EOL;
      end
`endif
      S_EOL: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream outputs decoded from state; data is forced to zero when not valid.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = top_byte;
      end
`ifdef ASM_TRACE_CR_EN
      S_CR: begin
        out_valid = 1'b1;
        out_data  = 8'h0D;
      end
`endif
      S_EOL: begin
        out_valid = 1'b1;
        out_data  = EOL_CHAR;
      end
      default: begin
        out_valid = 1'b0;
        out_data  = 8'h00;
      end
    endcase
  end

  // Saturating count of strobes that arrive while a line is still in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (asm_valid && (state_q != S_IDLE) && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_asm_trace_streamer.sv
// Directed bench for asm_trace_streamer: table of strings with hand-computed
// expected streams, plus hand-written sequences for the all-NUL, drop-counter
// and mid-line reset cases. A second instance with DROP_W=2 shares stimulus
// to exercise counter saturation.
module tb_asm_trace_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] asm;
  logic         asm_valid;
  logic [7:0]   out_data, out_data2;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic         busy, busy2;
  logic [15:0]  drop_cnt;
  logic [1:0]   drop_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asm_trace_streamer #(.NBYTES(32), .EOL_CHAR(8'h0A), .DROP_W(16)) u_dut (
    .clk(clk), .reset(reset), .asm(asm), .asm_valid(asm_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  asm_trace_streamer #(.NBYTES(32), .EOL_CHAR(8'h0A), .DROP_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .asm(asm), .asm_valid(asm_valid),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .busy(busy2), .drop_cnt(drop_cnt2)
  );

  typedef struct {
    string        name;
    logic [255:0] asm_v;
    logic [255:0] exp_v;   // expected characters, right-justified
    int           exp_len; // characters before the terminator
    int           first;   // edges after capture until out_valid
    logic [3:0]   pat;     // out_ready pattern, bit i used on cycle i%4
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string n, input logic [255:0] a,
                         input logic [255:0] e, input int len, input int first,
                         input logic [3:0] pat);
    vecs[i].name    = n;
    vecs[i].asm_v   = a;
    vecs[i].exp_v   = e;
    vecs[i].exp_len = len;
    vecs[i].first   = first;
    vecs[i].pat     = pat;
  endtask

  function automatic int total_bytes(input vec_t v);
`ifdef ASM_TRACE_CR_EN
    return v.exp_len + 2;
`else
    return v.exp_len + 1;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input vec_t v, input int i);
    if (i < v.exp_len) return v.exp_v[8*(v.exp_len-1-i) +: 8];
`ifdef ASM_TRACE_CR_EN
    if (i == v.exp_len) return 8'h0D;
`endif
    return 8'h0A;
  endfunction

  // Present a one-cycle strobe, then scramble asm so late changes are visible.
  task automatic strobe(input logic [255:0] a);
    asm = a;
    asm_valid = 1'b1;
    @(posedge clk); #1;
    asm_valid = 1'b0;
    asm = {32{8'hA5}};
  endtask

  task automatic run_vec(input vec_t v);
    int edges, n, g, cyc, total;
    logic rdy, hold;
    logic [7:0] hd;
    out_ready = 1'b0;
    strobe(v.asm_v);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check($sformatf("%s first_valid_edge", v.name), edges, v.first);
    total = total_bytes(v);
    n = 0; g = 0; cyc = 0;
    while (n < total && g < 400) begin
      rdy = v.pat[cyc % 4];
      out_ready = rdy;
      if (out_valid && rdy) begin
        check($sformatf("%s byte%0d", v.name, n), out_data, exp_byte(v, n));
        n++;
      end
      hold = out_valid && !rdy;
      hd = out_data;
      @(posedge clk); #1;
      g++; cyc++;
      if (hold) begin
        check($sformatf("%s stall_valid", v.name), out_valid, 1);
        check($sformatf("%s stall_data", v.name), out_data, hd);
      end
    end
    check($sformatf("%s byte_count", v.name), n, total);
    if (v.pat == 4'hF) check($sformatf("%s cycles", v.name), g, total);
    check($sformatf("%s busy_after", v.name), busy, 0);
    check($sformatf("%s valid_after", v.name), out_valid, 0);
    check($sformatf("%s data_after", v.name), out_data, 8'h00);
    $display("vector %s: %0d bytes, first valid after %0d edges", v.name, n, edges);
    out_ready = 1'b0;
  endtask

  initial begin
    int k, g, n;
    logic bad;
    logic [63:0] got;

    set_vec(0, "ab",    "ab",    "ab",    2,  31, 4'b1111);
    set_vec(1, "addu",  "addu $1,$2,$3", "addu $1,$2,$3", 13, 20, 4'b1001);
    set_vec(2, "inner_nul", 256'h410042, 256'h410042, 3, 30, 4'b0101);
    set_vec(3, "full32", "0123456789abcdefghijklmnopqrstuv",
            "0123456789abcdefghijklmnopqrstuv", 32, 1, 4'b1111);
    set_vec(4, "j",     "j",     "j",     1,  32, 4'b1111);

    reset = 1'b0; asm = '0; asm_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 8'h00);
    check("reset busy", busy, 0);
    check("reset drop_cnt", drop_cnt, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // All-NUL string: no output, busy for exactly NBYTES cycles.
    out_ready = 1'b1;
    strobe('0);
    k = 0; g = 0; bad = 1'b0;
    while (busy && g < 100) begin
      k++;
      if (out_valid) bad = 1'b1;
      @(posedge clk); #1;
      g++;
    end
    check("allnul no_valid", bad, 0);
    check("allnul busy_cycles", k, 32);
    $display("all-NUL: busy %0d cycles", k);

    // Drops: 3 during the line, 1 on the terminator accept edge.
    strobe("nop");
    repeat (3) begin
      asm_valid = 1'b1;
      @(posedge clk); #1;
      asm_valid = 1'b0;
    end
    got = '0; n = 0; g = 0;
    while (!(out_valid && out_data == 8'h0A) && g < 100) begin
      if (out_valid) begin
        got = {got[55:0], out_data};
        n++;
      end
      @(posedge clk); #1;
      g++;
    end
`ifdef ASM_TRACE_CR_EN
    check("drop stream", got[31:0], {"nop", 8'h0D});
    check("drop count_bytes", n, 4);
`else
    check("drop stream", got[31:0], {8'h00, "nop"});
    check("drop count_bytes", n, 3);
`endif
    asm_valid = 1'b1;
    @(posedge clk); #1;
    asm_valid = 1'b0;
    check("drop busy_fall", busy, 0);
    check("drop cnt16", drop_cnt, 4);
    check("drop cnt2_sat", drop_cnt2, 3);
    $display("drop test: drop_cnt=%0d drop_cnt(2b)=%0d", drop_cnt, drop_cnt2);
    // Strobe on the falling-busy cycle is captured, not dropped.
    strobe("x");
    check("recapture busy", busy, 1);
    check("recapture cnt", drop_cnt, 4);
    strobe("y");
    check("drop5 cnt16", drop_cnt, 5);
    check("drop5 cnt2_sat", drop_cnt2, 3);
    g = 0;
    while (busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain idle", busy, 0);

    // Reset in the middle of a line.
    strobe("lw");
    n = 0; g = 0;
    while (n < 2 && g < 100) begin
      if (out_valid) n++;
      @(posedge clk); #1;
      g++;
    end
    check("midreset bytes_before", n, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset drop_cnt", drop_cnt, 0);
    check("midreset busy", busy, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    $display("mid-line reset applied after %0d bytes", n);
    begin
      vec_t sw;
      sw.name = "sw"; sw.asm_v = "sw"; sw.exp_v = 256'h7377;
      sw.exp_len = 2; sw.first = 31; sw.pat = 4'b1111;
      run_vec(sw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asm_trace_streamer.md
# asm_trace_streamer

Consumer of the CPU's 256-bit ASCII disassembly bus (`asm`, right-justified Verilog string, leading NUL padding). On each retire strobe it captures the string and emits it as a byte stream over a valid/ready interface, stripping the leading NULs and appending an end-of-line character. It sits beside `mips` in simulation and FPGA builds, feeding a UART transmitter or a trace FIFO. New strings arriving while a transfer is in progress are dropped and counted.

## Interface
- `NBYTES`, 32 — bytes in `asm` (bus width = 8*NBYTES)
- `EOL_CHAR`, 8'h0A — terminator byte appended after each string
- `DROP_W`, 16 — width of the drop counter
- `clk`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-low; sampled on rising `clk`
- `asm`  in  8*NBYTES  — ASCII string; byte NBYTES-1 (MSBs) is the first character
- `asm_valid`  in  1  — one-cycle strobe: `asm` holds a new instruction string
- `out_data`  out  8  — current stream byte
- `out_valid`  out  1  — `out_data` is valid
- `out_ready`  in  1  — sink accepts the byte on this edge when `out_valid`=1
- `busy`  out  1  — 1 whenever state ≠ IDLE
- `drop_cnt`  out  DROP_W  — saturating count of strobes ignored while busy

## Operation
- States: IDLE, SKIP, SEND, EOL (plus CR when configured).
- IDLE: on `asm_valid`=1, load `asm` into shift register `sr`, load byte counter `cnt`=NBYTES, go to SKIP.
- SKIP: examine top byte `sr[8*NBYTES-1 -: 8]`.
  - Zero and `cnt`>1: shift `sr` left 8, `cnt`−1, stay.
  - Zero and `cnt`=1: string is all-NUL; go to IDLE, nothing emitted.
  - Nonzero: go to SEND (no shift).
- SEND: `out_valid`=1, `out_data`=top byte. On `out_ready`: shift, `cnt`−1; if `cnt` was 1, go to EOL (or CR), else stay. Interior NUL bytes after the first nonzero byte are sent unchanged.
- EOL: `out_valid`=1, `out_data`=EOL_CHAR; on `out_ready`, go to IDLE.
- `asm_valid`=1 in any state other than IDLE: strobe ignored, `drop_cnt`+1, saturating at all-ones. This includes the final EOL accept cycle.
- `out_data` is 8'h00 whenever `out_valid`=0.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, `sr`=0, `cnt`=0, `out_valid`=0, `out_data`=0, `busy`=0, `drop_cnt`=0. Reset overrides all other inputs and aborts any transfer mid-string with no further bytes.
- Capture edge E0. With N leading NUL bytes, SKIP occupies the edges E1..EN. SEND is entered on edge E(N+1), and `out_valid` rises after it.
- Throughput with `out_ready` held at 1: one byte per cycle, no bubbles between characters or before EOL.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable. `out_valid` never drops without an accept, except on reset.
- `busy` rises the cycle after capture and falls the cycle after the terminator is accepted. A strobe on that falling cycle (state now IDLE) is captured.
- `asm` is sampled only at the capture edge; later changes do not affect the stream.

## Configuration
- `ASM_TRACE_CR_EN` defined: a CR state is inserted between SEND and EOL. It emits 8'h0D with the same handshake, so each line ends 0x0D, EOL_CHAR.
- Undefined: SEND goes directly to EOL. The CR state and its logic are absent.

## Test plan
- Reset, then `asm`="ab" (0x6162 in the low bytes) strobed, `out_ready`=1 → `out_valid` first high after 31 edges; stream 0x61, 0x62, 0x0A on consecutive cycles; then `busy`=0.
- `asm`="addu $1,$2,$3" with `out_ready` toggling 1,0,0,1 → no byte lost or duplicated; `out_data` stable during stalls; 14 bytes total including 0x0A.
- All-zero `asm` strobed → `out_valid` stays 0; `busy` is high for 32 cycles, then low.
- Strobe "nop", then 3 more strobes while busy, plus 1 on the final accept edge → only "nop\n" emitted; `drop_cnt`=4. With DROP_W=2, 5 drops → `drop_cnt` saturates at 3.
- `reset` asserted after 2 bytes of "lw" → `out_valid`=0 and `drop_cnt`=0 the next cycle; next strobe "sw" streams cleanly as 0x73, 0x77, 0x0A.
- Build with `ASM_TRACE_CR_EN`, strobe "j" → stream 0x6A, 0x0D, 0x0A.
